// File: rtl/uart_prog_loader.sv
// UART program loader: receives a framed program (A5, N, 4*N little-endian bytes,
// 8-bit additive checksum) and writes it word by word into instruction memory.
module uart_prog_loader #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned MEM_SIZE      = 64,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned DIV       = CLK_HZ / BAUD;
  localparam int unsigned MAX_WORDS = MEM_SIZE / 4;
  localparam int unsigned TO_LIMIT  = TIMEOUT_BYTES * 10 * DIV;
  localparam int unsigned CW        = $clog2(DIV);
  localparam int unsigned TW        = $clog2(TO_LIMIT);
  localparam int unsigned WW        = $clog2(MAX_WORDS + 1);

  localparam logic [CW-1:0] C_HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] C_BIT_END  = CW'(DIV - 1);
  // Two short of the limit so that error is visible exactly TO_LIMIT cycles after byte_valid
  localparam logic [TW-1:0] C_TO_END   = TW'(TO_LIMIT - 2);
  localparam logic [7:0]    C_SYNC     = 8'hA5;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} ld_state_t;

  logic            r_rx_meta;
  logic            r_rx_sync;
  rx_state_t       r_rx_state;
  rx_state_t       w_rx_next;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            r_byte_valid;
  logic            r_frame_err;
  logic            w_half_hit;
  logic            w_bit_hit;

  ld_state_t       r_ld_state;
  ld_state_t       w_ld_next;
  logic [WW-1:0]   r_len;
  logic [WW-1:0]   r_word_idx;
  logic [1:0]      r_byte_idx;
  logic [23:0]     r_word;
  logic [7:0]      r_sum;
  logic [TW-1:0]   r_to_cnt;
  logic            r_mem_we;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic            w_timeout;
  logic            w_len_ok;
  logic            w_in_frame;
  logic            w_is_sync;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_half_hit = (r_rx_cnt == C_HALF_END);
  assign w_bit_hit  = (r_rx_cnt == C_BIT_END);

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
      RX_START: if (w_half_hit) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_hit && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_bit_hit) w_rx_next = RX_WAIT;
      RX_WAIT:  if (r_rx_sync) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_next;
      r_byte_valid <= (r_rx_state == RX_STOP) && w_bit_hit && r_rx_sync;
      r_frame_err  <= (r_rx_state == RX_STOP) && w_bit_hit && !r_rx_sync;
      if ((w_rx_next != r_rx_state) || w_bit_hit ||
          (r_rx_state == RX_IDLE) || (r_rx_state == RX_WAIT))
        r_rx_cnt <= '0;
      else
        r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state == RX_START)
        r_rx_bit <= '0;
      if ((r_rx_state == RX_DATA) && w_bit_hit) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
    end
  end

  assign w_timeout  = (r_to_cnt == C_TO_END);
  assign w_len_ok   = (r_rx_shift != 8'd0) && (32'(r_rx_shift) <= 32'(MAX_WORDS));
  assign w_in_frame = (r_ld_state == LEN) || (r_ld_state == DATA) || (r_ld_state == CSUM);
  assign w_is_sync  = r_byte_valid && (r_rx_shift == C_SYNC);

  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      IDLE: if (w_is_sync) w_ld_next = LEN;
      LEN: begin
        if (r_frame_err)       w_ld_next = ERR;
        else if (r_byte_valid) w_ld_next = w_len_ok ? DATA : ERR;
        else if (w_timeout)    w_ld_next = ERR;
      end
      DATA: begin
        // The last word's write strobe is issued while still in DATA; CSUM follows it
        if (r_frame_err)                             w_ld_next = ERR;
        else if (r_byte_valid)                       w_ld_next = DATA;
        else if (r_mem_we && (r_word_idx == r_len))  w_ld_next = CSUM;
        else if (w_timeout)                          w_ld_next = ERR;
      end
      CSUM: begin
        if (r_frame_err)       w_ld_next = ERR;
        else if (r_byte_valid) w_ld_next = (r_rx_shift == r_sum) ? DONE : ERR;
        else if (w_timeout)    w_ld_next = ERR;
      end
      DONE, ERR: w_ld_next = w_is_sync ? LEN : IDLE;
      default:   w_ld_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_ld_state  <= IDLE;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_sum       <= '0;
      r_to_cnt    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_ld_state <= w_ld_next;
      r_mem_we   <= 1'b0;

      if (r_byte_valid || !w_in_frame)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;

      if ((r_ld_state == LEN) && (w_ld_next == DATA)) begin
        r_len      <= WW'(r_rx_shift);
        r_word_idx <= '0;
        r_byte_idx <= '0;
        r_sum      <= '0;
      end

      if ((r_ld_state == DATA) && r_byte_valid) begin
        r_sum <= r_sum + r_rx_shift;
        case (r_byte_idx)
          2'd0: r_word[7:0]   <= r_rx_shift;
          2'd1: r_word[15:8]  <= r_rx_shift;
          2'd2: r_word[23:16] <= r_rx_shift;
          default: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= 32'({r_word_idx, 2'b00});
            r_mem_wdata <= {r_rx_shift, r_word};
            r_word_idx  <= r_word_idx + 1'b1;
          end
        endcase
        r_byte_idx <= r_byte_idx + 1'b1;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = (r_ld_state != IDLE);
  assign done      = (r_ld_state == DONE);
  assign error     = (r_ld_state == ERR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed frames plus randomized frames
// checked against a frame-level model of the expected writes and outcome.
module tb_uart_prog_loader;

  localparam int CLK_HZ   = 160;
  localparam int BAUD     = 10;
  localparam int DIV      = CLK_HZ / BAUD;
  localparam int MEM_SIZE = 64;
  localparam int MAXW     = MEM_SIZE / 4;
  // Start-bit edge to byte_valid: 2 synchronizer flops, 1 idle detect, half bit, 9 bits
  localparam int RX_LAT   = 9 * DIV + DIV / 2 + 3;
  localparam int TO_CYC   = 4 * 10 * DIV;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx      = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  uart_prog_loader #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .MEM_SIZE(MEM_SIZE),
    .TIMEOUT_BYTES(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .rx(rx),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          n_done;
  int          n_err;
  int          err_cyc;
  logic        hold_at_pulse;
  int          n_we_unheld = 0;
  int          last_start;
  logic [31:0] frame_w[MAXW];

  always @(negedge sys_clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      if (!cpu_hold) n_we_unheld++;
    end
    if (done) begin
      n_done++;
      hold_at_pulse = cpu_hold;
    end
    if (error) begin
      n_err++;
      err_cyc = cyc;
      hold_at_pulse = cpu_hold;
    end
  end

  initial begin
    repeat (90000) @(posedge sys_clk);
    $display("FAIL watchdog: got cycle %0d required finish before it", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    n_done        = 0;
    n_err         = 0;
    err_cyc       = -1;
    hold_at_pulse = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge sys_clk);
    #1;
    last_start = cyc;
    rx = 1'b0;
    repeat (DIV) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (DIV) @(posedge sys_clk);
    end
    #1 rx = stop;
    repeat (DIV) @(posedge sys_clk);
    #1 rx = 1'b1;
  endtask

  // Expected outcome of a whole frame: n words at 4*i, then exactly one done or error
  task automatic check_outcome(input string tag, input int n, input bit good);
    check({tag, "_nwr"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check({tag, "_addr"}, wr_addr_q[i], 32'(4 * i));
      check({tag, "_data"}, wr_data_q[i], frame_w[i]);
    end
    check({tag, "_done"}, n_done, good ? 1 : 0);
    check({tag, "_err"}, n_err, good ? 0 : 1);
    check({tag, "_hold_pulse"}, hold_at_pulse, 1'b1);
    check({tag, "_hold_after"}, cpu_hold, 1'b0);
  endtask

  task automatic run_frame(input string tag, input int n, input bit bad_sum);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'd0;
    clear_mon();
    send_byte(8'hA5, 1'b1);
    check({tag, "_hold_len"}, cpu_hold, 1'b1);
    send_byte(8'(n), 1'b1);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = frame_w[w][8*k +: 8];
        s = s + b;
        send_byte(b, 1'b1);
      end
    end
    send_byte(bad_sum ? s + 8'd1 : s, 1'b1);
    repeat (4) @(posedge sys_clk);
    #1;
    check_outcome(tag, n, !bad_sum);
  endtask

  task automatic len_error(input string tag, input logic [7:0] len);
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(len, 1'b1);
    repeat (4) @(posedge sys_clk);
    #1;
    check_outcome(tag, 0, 1'b0);
  endtask

  task automatic load_test1();
    frame_w[0] = 32'h00100513;
    frame_w[1] = 32'h00200593;
  endtask

  initial begin
    logic [7:0] g;
    int         n;
    clear_mon();
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_hold", cpu_hold, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", error, 1'b0);
    sys_rst = 1'b0;
    repeat (5) @(posedge sys_clk);

    load_test1();
    run_frame("good", 2, 1'b0);
    check("hold_addr", mem_addr, 32'h4);
    check("hold_wdata", mem_wdata, 32'h00200593);

    run_frame("badsum", 2, 1'b1);

    len_error("len0", 8'h00);
    len_error("len17", 8'h11);

    for (int i = 0; i < MAXW; i++) frame_w[i] = $urandom;
    run_frame("max", MAXW, 1'b0);

    clear_mon();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    @(posedge sys_clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 rx = 1'b1;
    repeat (2 * DIV) @(posedge sys_clk);
    #1;
    check("noise_err", n_err, 0);
    check("noise_hold", cpu_hold, 1'b0);
    check("noise_nwr", wr_addr_q.size(), 0);
    load_test1();
    run_frame("after_noise", 2, 1'b0);

    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b0);
    repeat (4) @(posedge sys_clk);
    #1;
    check_outcome("stopbit", 0, 1'b0);

    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h13, 1'b1);
    for (int i = 0; i < 1000 && n_err == 0; i++) @(posedge sys_clk);
    check("timeout_cycle", err_cyc, last_start + RX_LAT + TO_CYC);
    @(posedge sys_clk);
    #1;
    check_outcome("timeout", 0, 1'b0);

    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int k = 0; k < 6; k++) begin
      g = (k < 4) ? frame_w[0][8*k +: 8] : frame_w[1][8*(k-4) +: 8];
      send_byte(g, 1'b1);
    end
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_wdata", mem_wdata, 32'h0);
    check("mid_rst_hold", cpu_hold, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", error, 1'b0);
    check("mid_rst_nwr", wr_addr_q.size(), 1);
    if (wr_data_q.size() > 0) check("mid_rst_w0", wr_data_q[0], 32'h00100513);
    repeat (3) @(posedge sys_clk);
    run_frame("after_rst", 2, 1'b0);

    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, MAXW);
      for (int i = 0; i < n; i++) frame_w[i] = $urandom;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1'b1);
      end
      run_frame("rand", n, $urandom_range(0, 3) == 0);
    end

    check("we_without_hold", n_we_unheld, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Writer side of the instruction memory: receives a program over a UART RX line and writes 32-bit words into instruction memory.
- The core only ever reads that memory through pc.
- Holds the core (cpu_hold) for the whole load so pc and the register file restart cleanly afterwards.
- Framed protocol: sync byte, word count, little-endian payload, 8-bit additive checksum.

Parameters:
- CLK_HZ, 50000000, sys_clk frequency in Hz.
- BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD (integer division), must be >= 4.
- MEM_SIZE, 64, instruction memory size in bytes; max words = MEM_SIZE/4.
- TIMEOUT_BYTES, 4, inter-byte timeout in byte times (1 byte time = 10*DIV cycles).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset.
- rx  in  1  UART receive line, idle high, asynchronous to sys_clk.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  32  byte address of the write, always word-aligned.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  high while a frame is being loaded.
- done  out  1  one-cycle pulse: frame loaded, checksum good.
- error  out  1  one-cycle pulse: frame aborted or bad.

Interface (already decided): one clock, sys_clk; reset sys_rst is synchronous and active-high.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE; RX goes to idle; counters clear.
  - Reset mid-load drops cpu_hold on the next edge. No partial-word write occurs.
- RX front end:
  - rx passes through a 2-flop synchronizer; the synchronizer resets to 1.
  - A falling edge in RX_IDLE starts a count of DIV/2 cycles. If the line is still low, the start bit is accepted; otherwise it is a glitch and RX returns to idle with no byte.
  - 8 data bits, LSB first, are sampled every DIV cycles.
  - The stop bit is sampled DIV cycles later.
  - stop=1: the internal byte_valid pulses for 1 cycle in that sample cycle.
  - stop=0: the internal frame_err pulses instead and the byte is dropped.
  - After the stop sample, RX waits for the line to be high before re-arming.
- Loader FSM: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE: bytes other than 0xA5 and frame_err are ignored; 0xA5 goes to LEN.
  - LEN: byte N; N==0 or N>MEM_SIZE/4 goes to ERR; otherwise store N, word_idx=0, byte_idx=0, sum=0, go to DATA.
  - DATA: each byte goes into lane byte_idx (byte 0 = bits 7:0); sum = (sum+byte) mod 256. On the 4th byte, the next cycle has mem_we=1, mem_addr=word_idx*4, mem_wdata=assembled word; then word_idx++ and byte_idx=0. After word N is written, go to CSUM.
  - CSUM: byte==sum goes to DONE, else ERR. Words already written stay written.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: error=1 for one cycle, then IDLE.
- cpu_hold:
  - High from the cycle after the sync byte is accepted through the DONE/ERR cycle inclusive.
  - Low in IDLE.
- frame_err in LEN, DATA or CSUM goes to ERR.
- Timeout:
  - Counter clears on every byte_valid and counts only in LEN, DATA and CSUM.
  - Reaching TIMEOUT_BYTES*10*DIV cycles goes to ERR.
- mem_we is never high outside DATA.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- A byte arriving while in DONE or ERR is processed by IDLE rules.
- Simultaneous byte_valid and timeout expiry: the byte wins.

Test Plan:
Bench parameters: CLK_HZ=160, BAUD=10 (DIV=16), MEM_SIZE=64.

1. Good frame: send A5 02 13 05 10 00 93 05 20 00 E0 -> exactly two mem_we pulses, (0x0, 0x00100513) then (0x4, 0x00200593); done pulses once; error stays 0; cpu_hold high from after A5 until the done cycle.
2. Bad checksum: same frame with final byte E1 -> both writes occur; error pulses once; done stays 0; cpu_hold low afterwards.
3. Length limits:
   - A5 00 -> error right after the LEN byte, no mem_we.
   - A5 11 (17 > 16) -> error.
   - A5 10 plus 64 data bytes plus correct sum -> 16 writes, addresses 0x00 to 0x3C, then done.
4. Noise:
   - Garbage bytes 00 FF 5A, then a 4-cycle low glitch on rx (< DIV/2), then the frame from test 1 -> no spurious byte, no error.
   - Load identical to test 1.
5. Errors mid-frame:
   - A stop bit of 0 on the 3rd data byte -> error, no mem_we.
   - Separately, stop after A5 02 13 -> error exactly 640 cycles after the last byte_valid; cpu_hold then drops.
6. Reset:
   - Assert sys_rst for 1 cycle after 6 payload bytes of test 1 -> next cycle all outputs are 0.
   - Exactly one write (word 0) was issued before reset.
   - Re-sending the full frame from test 1 loads it normally with done.
